// File: rtl/pe_router_pkg.sv
// Shared constants and conf-field helpers for the CGRA PE router node.
// Field order in conf, LSB first: fifo_en, cell mask, output select.
package pe_router_pkg;

  localparam int SEL_OFF = 0;

  function automatic int sel_width(input int np);
    return $clog2(np + 2);
  endfunction

  function automatic int sel_port(input int p);
    return p + 1;
  endfunction

  function automatic int sel_cell(input int np);
    return np + 1;
  endfunction

  function automatic int fen_lsb();
    return 0;
  endfunction

  function automatic int mask_lsb(input int np);
    return np;
  endfunction

  function automatic int sel_lsb(input int np, input int nci);
    return np * (1 + nci);
  endfunction

  function automatic int conf_width(input int np, input int nci);
    return np * (sel_width(np) + nci + 1);
  endfunction

endpackage

// File: rtl/pe_router_node_fork.sv
// Eager fork: each member consumer takes the head once, in any order;
// the head pops once every member has it.
module eager_fork #(
  parameter int NUM_OUT = 2
) (
  input  logic               clk_bs,
  input  logic               rst_n_bs,
  input  logic               flush,
  input  logic               in_v,
  output logic               in_r,
  input  logic [NUM_OUT-1:0] member,
  output logic [NUM_OUT-1:0] out_v,
  input  logic [NUM_OUT-1:0] out_r,
  output logic               busy
);

  logic [NUM_OUT-1:0] sent_q;
  logic [NUM_OUT-1:0] fire;
  logic               done;

  assign out_v = {NUM_OUT{in_v}} & member & ~sent_q;
  assign fire  = out_v & out_r;
  assign done  = &(~member | sent_q | fire);
  // no members means no pop: the head stalls rather than being dropped
  assign in_r  = in_v & (|member) & done;
  assign busy  = |sent_q;

  always_ff @(posedge clk_bs) begin
    if (!rst_n_bs || flush) begin
      sent_q <= '0;
    end else if (in_r) begin
      sent_q <= '0;
    end else begin
      sent_q <= sent_q | fire;
    end
  end

endmodule

// File: rtl/pe_router_node.sv
// CGRA PE routing node: per-input FIFO (or bypass) feeding an eager fork
// to outputs and cell operand slots; cell result eagerly forked to outputs.
module pe_router_node
  import pe_router_pkg::*;
#(
  parameter  int DATA_WIDTH  = 32,
  parameter  int NUM_PORTS   = 4,
  parameter  int FIFO_DEPTH  = 2,
  parameter  int NUM_CELL_IN = 3,
  localparam int SEL_W       = sel_width(NUM_PORTS),
  localparam int CONF_W      = conf_width(NUM_PORTS, NUM_CELL_IN)
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  din_i,
  input  logic [NUM_PORTS-1:0]                  din_v_i,
  output logic [NUM_PORTS-1:0]                  din_r_o,
  output logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  dout_o,
  output logic [NUM_PORTS-1:0]                  dout_v_o,
  input  logic [NUM_PORTS-1:0]                  dout_r_i,
  output logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  cell_din_o,
  output logic [NUM_PORTS-1:0][NUM_CELL_IN-1:0] cell_din_v_o,
  input  logic [NUM_CELL_IN-1:0]                cell_din_r_i,
  input  logic [DATA_WIDTH-1:0]                 cell_dout_i,
  input  logic                                  cell_dout_v_i,
  output logic                                  cell_dout_r_o,
  input  logic                                  conf_en_i,
  input  logic [CONF_W-1:0]                     conf_i,
  output logic                                  idle_o
);

  localparam int NO       = NUM_PORTS + NUM_CELL_IN;
  localparam int PW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW       = $clog2(FIFO_DEPTH + 1);
  localparam int FEN_LSB  = fen_lsb();
  localparam int MASK_LSB = mask_lsb(NUM_PORTS);
  localparam int SEL_LSB  = sel_lsb(NUM_PORTS, NUM_CELL_IN);
  localparam int SEL_CELL = sel_cell(NUM_PORTS);

  logic [CONF_W-1:0]                     conf_q;
  logic [NUM_PORTS-1:0][SEL_W-1:0]       sel;
  logic [NUM_PORTS-1:0][NUM_CELL_IN-1:0] mask;
  logic [NUM_PORTS-1:0]                  fifo_en;
  logic                                  blk;

  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  head;
  logic [NUM_PORTS-1:0]                  head_v;
  logic [NUM_PORTS-1:0]                  fork_pop;
  logic [NUM_PORTS-1:0]                  fork_busy;
  logic [NUM_PORTS-1:0]                  fifo_empty;
  logic [NUM_PORTS-1:0][NO-1:0]          offer;
  logic [NUM_PORTS-1:0]                  cell_mem;
  logic [NUM_PORTS-1:0]                  cell_offer;
  logic                                  cell_busy;

  assign fifo_en = conf_q[FEN_LSB +: NUM_PORTS];
  assign mask    = conf_q[MASK_LSB +: NUM_PORTS*NUM_CELL_IN];
  assign sel     = conf_q[SEL_LSB +: NUM_PORTS*SEL_W];
  // no transfer may complete during reset or a reconfiguration cycle
  assign blk     = conf_en_i | ~rst_ni;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      conf_q <= '0;
    end else if (conf_en_i) begin
      conf_q <= conf_i;
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_in
    logic [FIFO_DEPTH-1:0][DATA_WIDTH-1:0] mem;
    logic [PW-1:0]                         wr_ptr;
    logic [PW-1:0]                         rd_ptr;
    logic [CW-1:0]                         cnt;
    logic                                  full;
    logic                                  push;
    logic                                  pop;
    logic [NO-1:0]                         memb;
    logic [NO-1:0]                         rdy;

    assign full          = (cnt == CW'(FIFO_DEPTH));
    assign fifo_empty[p] = (cnt == '0);
    assign push          = fifo_en[p] & din_v_i[p] & ~full & ~blk;
    assign pop           = fifo_en[p] & fork_pop[p];
    assign din_r_o[p]    = fifo_en[p] ? (~full & ~blk) : fork_pop[p];
    assign head[p]       = fifo_en[p] ? mem[rd_ptr] : din_i[p];
    assign head_v[p]     = fifo_en[p] ? ~fifo_empty[p] : din_v_i[p];

    always_ff @(posedge clk_i) begin
      if (!rst_ni || conf_en_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (push) begin
          wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH-1)) ? '0 : wr_ptr + 1'b1;
        end
        if (pop) begin
          rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH-1)) ? '0 : rd_ptr + 1'b1;
        end
        unique case ({push, pop})
          2'b10:   cnt <= cnt + 1'b1;
          2'b01:   cnt <= cnt - 1'b1;
          default: cnt <= cnt;
        endcase
      end
    end

    always_ff @(posedge clk_i) begin
      if (push) begin
        mem[wr_ptr] <= din_i[p];
      end
    end

    always_comb begin
      memb = '0;
      for (int q = 0; q < NUM_PORTS; q++) begin
        memb[q] = (sel[q] == SEL_W'(sel_port(p))) && (q != p);
      end
      memb[NO-1:NUM_PORTS] = mask[p];
    end

    assign rdy = {cell_din_r_i, dout_r_i};

    eager_fork #(
      .NUM_OUT (NO)
    ) u_fork (
      .clk_bs   (clk_i),
      .rst_n_bs (rst_ni),
      .flush    (conf_en_i),
      .in_v     (head_v[p] & ~blk),
      .in_r     (fork_pop[p]),
      .member   (memb),
      .out_v    (offer[p]),
      .out_r    (rdy),
      .busy     (fork_busy[p])
    );

    assign cell_din_o[p]   = head[p];
    assign cell_din_v_o[p] = offer[p][NO-1:NUM_PORTS];
  end

  always_comb begin
    cell_mem = '0;
    for (int q = 0; q < NUM_PORTS; q++) begin
      cell_mem[q] = (sel[q] == SEL_W'(SEL_CELL));
    end
  end

  eager_fork #(
    .NUM_OUT (NUM_PORTS)
  ) u_cell_fork (
    .clk_bs   (clk_i),
    .rst_n_bs (rst_ni),
    .flush    (conf_en_i),
    .in_v     (cell_dout_v_i & ~blk),
    .in_r     (cell_dout_r_o),
    .member   (cell_mem),
    .out_v    (cell_offer),
    .out_r    (dout_r_i),
    .busy     (cell_busy)
  );

  // off codes and self-selection fall through to valid 0, data 0
  always_comb begin
    dout_v_o = '0;
    dout_o   = '0;
    for (int q = 0; q < NUM_PORTS; q++) begin
      for (int s = 0; s < NUM_PORTS; s++) begin
        if (sel[q] == SEL_W'(sel_port(s)) && s != q) begin
          dout_v_o[q] = offer[s][q];
          dout_o[q]   = head[s];
        end
      end
      if (sel[q] == SEL_W'(SEL_CELL)) begin
        dout_v_o[q] = cell_offer[q];
        dout_o[q]   = cell_dout_i;
      end
    end
  end

  assign idle_o = (&fifo_empty) & ~(|fork_busy) & ~cell_busy;

endmodule

// File: tb/tb_pe_router_node.sv
// Scoreboard bench for pe_router_node: routing, eager fork, bypass,
// cell result fan-out and reconfiguration flush.
module tb_pe_router_node;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [3:0][31:0] din_i;
  logic [3:0]       din_v_i;
  logic [3:0]       din_r_o;
  logic [3:0][31:0] dout_o;
  logic [3:0]       dout_v_o;
  logic [3:0]       dout_r_i;
  logic [3:0][31:0] cell_din_o;
  logic [3:0][2:0]  cell_din_v_o;
  logic [2:0]       cell_din_r_i;
  logic [31:0]      cell_dout_i;
  logic             cell_dout_v_i;
  logic             cell_dout_r_o;
  logic             conf_en;
  logic [27:0]      conf;
  logic             idle_o;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] exp_out  [4][$];
  logic [31:0] exp_slot [3][$];

  always #5 clk = ~clk;

  pe_router_node dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .din_i         (din_i),
    .din_v_i       (din_v_i),
    .din_r_o       (din_r_o),
    .dout_o        (dout_o),
    .dout_v_o      (dout_v_o),
    .dout_r_i      (dout_r_i),
    .cell_din_o    (cell_din_o),
    .cell_din_v_o  (cell_din_v_o),
    .cell_din_r_i  (cell_din_r_i),
    .cell_dout_i   (cell_dout_i),
    .cell_dout_v_i (cell_dout_v_i),
    .cell_dout_r_o (cell_dout_r_o),
    .conf_en_i     (conf_en),
    .conf_i        (conf),
    .idle_o        (idle_o)
  );

  function automatic logic [27:0] mk_conf(
    input logic [3:0][2:0] s,
    input logic [3:0][2:0] m,
    input logic [3:0]      f
  );
    return {s, m, f};
  endfunction

  task automatic edge_();
    @(posedge clk);
    #1;
  endtask

  // sample mid-cycle and retire every transfer that will complete at the next edge
  task automatic tick();
    logic [31:0] e;
    @(negedge clk);
    for (int q = 0; q < 4; q++) begin
      if (dout_v_o[q] && dout_r_i[q]) begin
        n_cmp++;
        if (exp_out[q].size() == 0) begin
          n_err++;
          $display("FAIL sb_out%0d unexpected: got %h want none", q, dout_o[q]);
        end else begin
          e = exp_out[q].pop_front();
          if (dout_o[q] !== e) begin
            n_err++;
            $display("FAIL sb_out%0d: got %h want %h", q, dout_o[q], e);
          end
        end
      end
    end
    for (int k = 0; k < 3; k++) begin
      for (int p = 0; p < 4; p++) begin
        if (cell_din_v_o[p][k] && cell_din_r_i[k]) begin
          n_cmp++;
          if (exp_slot[k].size() == 0) begin
            n_err++;
            $display("FAIL sb_slot%0d unexpected: got %h want none", k, cell_din_o[p]);
          end else begin
            e = exp_slot[k].pop_front();
            if (cell_din_o[p] !== e) begin
              n_err++;
              $display("FAIL sb_slot%0d: got %h want %h", k, cell_din_o[p], e);
            end
          end
        end
      end
    end
  endtask

  task automatic sb_end(input string name);
    int left;
    left = 0;
    for (int q = 0; q < 4; q++) left += exp_out[q].size();
    for (int k = 0; k < 3; k++) left += exp_slot[k].size();
    n_cmp++;
    if (left != 0) begin
      n_err++;
      $display("FAIL %s undelivered: got %0d left want 0", name, left);
    end
    for (int q = 0; q < 4; q++) exp_out[q].delete();
    for (int k = 0; k < 3; k++) exp_slot[k].delete();
  endtask

  task automatic set_conf(input logic [27:0] c);
    edge_();
    din_v_i       = '0;
    dout_r_i      = '0;
    cell_din_r_i  = '0;
    cell_dout_v_i = 1'b0;
    conf_en       = 1'b1;
    conf          = c;
    tick();
    n_cmp++;
    if (dout_v_o !== 4'h0 || din_r_o !== 4'h0 || cell_dout_r_o !== 1'b0) begin
      n_err++;
      $display("FAIL conf_cycle: got v=%b r=%b cr=%b want 0", dout_v_o, din_r_o, cell_dout_r_o);
    end
    edge_();
    conf_en = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    din_i         = '0;
    din_v_i       = '1;
    dout_r_i      = '1;
    cell_din_r_i  = '1;
    cell_dout_i   = 32'h0;
    cell_dout_v_i = 1'b1;
    conf_en       = 1'b0;
    conf          = '0;
    edge_();
    tick();
    n_cmp++;
    if (dout_v_o !== 4'h0 || din_r_o !== 4'h0 || cell_dout_r_o !== 1'b0
        || cell_din_v_o !== 12'h0) begin
      n_err++;
      $display("FAIL rst_hold: got v=%b r=%b cr=%b want 0", dout_v_o, din_r_o, cell_dout_r_o);
    end
    edge_();
    rst_n         = 1'b1;
    din_v_i       = '0;
    cell_dout_v_i = 1'b0;
    tick();
    n_cmp++;
    if (idle_o !== 1'b1 || dout_v_o !== 4'h0) begin
      n_err++;
      $display("FAIL rst_idle: got idle=%b v=%b want 1/0000", idle_o, dout_v_o);
    end
    set_conf(mk_conf('0, '0, 4'hF));
    edge_();
    tick();
    n_cmp++;
    if (din_r_o !== 4'hF) begin
      n_err++;
      $display("FAIL rst_ready: got %b want 1111", din_r_o);
    end
  endtask

  task automatic test_route();
    int w;
    set_conf(mk_conf({3'd0, 3'd1, 3'd0, 3'd0}, '0, 4'hF));
    edge_();
    dout_r_i[2] = 1'b1;
    din_v_i[0]  = 1'b1;
    din_i[0]    = 32'hA5;
    exp_out[2].push_back(32'hA5);
    tick();
    n_cmp++;
    if (din_r_o[0] !== 1'b1 || dout_v_o[2] !== 1'b0) begin
      n_err++;
      $display("FAIL route_lat0: got r=%b v=%b want 1/0", din_r_o[0], dout_v_o[2]);
    end
    edge_();
    din_v_i[0] = 1'b0;
    tick();
    n_cmp++;
    if (dout_v_o[2] !== 1'b1 || dout_o[2] !== 32'hA5) begin
      n_err++;
      $display("FAIL route_lat1: got v=%b d=%h want 1/a5", dout_v_o[2], dout_o[2]);
    end
    w = 0;
    for (int i = 0; i < 4; i++) begin
      edge_();
      dout_r_i[2] = 1'b0;
      din_v_i[0]  = 1'b1;
      din_i[0]    = 32'h100 + w;
      tick();
      if (din_r_o[0]) begin
        exp_out[2].push_back(32'h100 + w);
        w++;
      end
    end
    n_cmp++;
    if (w != 2 || din_r_o[0] !== 1'b0) begin
      n_err++;
      $display("FAIL route_full: got acc=%0d r=%b want 2/0", w, din_r_o[0]);
    end
    edge_();
    din_v_i[0]  = 1'b0;
    dout_r_i[2] = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      edge_();
      tick();
    end
    sb_end("route");
  endtask

  task automatic test_fork();
    set_conf(mk_conf({3'd2, 3'd0, 3'd0, 3'd2}, {3'd0, 3'd0, 3'd1, 3'd0}, 4'hF));
    for (int c = 1; c <= 6; c++) begin
      edge_();
      din_v_i[1]      = (c <= 2);
      din_i[1]        = (c == 1) ? 32'h1234 : 32'h5678;
      dout_r_i[0]     = (c == 3);
      cell_din_r_i[0] = (c == 4);
      dout_r_i[3]     = (c == 5);
      if (c <= 2) begin
        exp_out[0].push_back(din_i[1]);
        exp_out[3].push_back(din_i[1]);
        exp_slot[0].push_back(din_i[1]);
      end
      tick();
      if (c == 4) begin
        n_cmp++;
        if (din_r_o[1] !== 1'b0 || dout_v_o[0] !== 1'b0) begin
          n_err++;
          $display("FAIL fork_c4: got r=%b v0=%b want 0/0", din_r_o[1], dout_v_o[0]);
        end
      end
      if (c == 5) begin
        n_cmp++;
        if (dout_v_o[3] !== 1'b1 || cell_din_v_o[1][0] !== 1'b0) begin
          n_err++;
          $display("FAIL fork_c5: got v3=%b s0=%b want 1/0", dout_v_o[3], cell_din_v_o[1][0]);
        end
      end
      if (c == 6) begin
        n_cmp++;
        if (din_r_o[1] !== 1'b1 || dout_v_o[0] !== 1'b1 || dout_o[0] !== 32'h5678) begin
          n_err++;
          $display("FAIL fork_pop: got r=%b v0=%b d=%h want 1/1/5678",
                   din_r_o[1], dout_v_o[0], dout_o[0]);
        end
      end
    end
    edge_();
    dout_r_i     = '1;
    cell_din_r_i = '1;
    tick();
    edge_();
    tick();
    sb_end("fork");
  endtask

  task automatic test_bypass();
    set_conf(mk_conf({3'd0, 3'd0, 3'd4, 3'd0}, '0, 4'b0111));
    edge_();
    din_v_i[3]  = 1'b1;
    din_i[3]    = 32'hCAFE;
    dout_r_i[1] = 1'b1;
    exp_out[1].push_back(32'hCAFE);
    tick();
    n_cmp++;
    if (dout_v_o[1] !== 1'b1 || dout_o[1] !== 32'hCAFE || din_r_o[3] !== 1'b1) begin
      n_err++;
      $display("FAIL bypass_pass: got v=%b d=%h r=%b want 1/cafe/1",
               dout_v_o[1], dout_o[1], din_r_o[3]);
    end
    edge_();
    din_i[3]    = 32'hD00D;
    dout_r_i[1] = 1'b0;
    tick();
    n_cmp++;
    if (din_r_o[3] !== 1'b0 || dout_v_o[1] !== 1'b1) begin
      n_err++;
      $display("FAIL bypass_stall: got r=%b v=%b want 0/1", din_r_o[3], dout_v_o[1]);
    end
    edge_();
    din_v_i[3] = 1'b0;
    tick();
    sb_end("bypass");
  endtask

  task automatic test_cell();
    set_conf(mk_conf({3'd0, 3'd5, 3'd0, 3'd5}, '0, 4'hF));
    for (int c = 1; c <= 3; c++) begin
      edge_();
      cell_dout_v_i = 1'b1;
      cell_dout_i   = 32'hBEEF;
      dout_r_i[0]   = 1'b1;
      dout_r_i[2]   = (c == 3);
      if (c == 1) begin
        exp_out[0].push_back(32'hBEEF);
        exp_out[2].push_back(32'hBEEF);
      end
      tick();
      n_cmp++;
      if (cell_dout_r_o !== (c == 3)) begin
        n_err++;
        $display("FAIL cell_ready_c%0d: got %b want %b", c, cell_dout_r_o, (c == 3));
      end
      if (c == 2) begin
        n_cmp++;
        if (dout_v_o[0] !== 1'b0 || dout_v_o[2] !== 1'b1) begin
          n_err++;
          $display("FAIL cell_sent: got v0=%b v2=%b want 0/1", dout_v_o[0], dout_v_o[2]);
        end
      end
    end
    edge_();
    cell_dout_v_i = 1'b0;
    dout_r_i      = '0;
    tick();
    sb_end("cell");
  endtask

  task automatic test_flush();
    logic [27:0] c;
    c = mk_conf({3'd0, 3'd1, 3'd0, 3'd0}, '0, 4'hF);
    set_conf(c);
    for (int i = 0; i < 2; i++) begin
      edge_();
      din_v_i[0] = 1'b1;
      din_i[0]   = 32'hE1 + i;
      tick();
    end
    edge_();
    din_v_i[0] = 1'b0;
    tick();
    n_cmp++;
    if (idle_o !== 1'b0) begin
      n_err++;
      $display("FAIL flush_busy: got idle=%b want 0", idle_o);
    end
    edge_();
    conf_en     = 1'b1;
    conf        = c;
    dout_r_i[2] = 1'b1;
    din_v_i[0]  = 1'b1;
    din_i[0]    = 32'hE3;
    tick();
    n_cmp++;
    if (dout_v_o !== 4'h0 || din_r_o !== 4'h0) begin
      n_err++;
      $display("FAIL flush_cycle: got v=%b r=%b want 0/0", dout_v_o, din_r_o);
    end
    edge_();
    conf_en    = 1'b0;
    din_v_i[0] = 1'b0;
    tick();
    n_cmp++;
    if (idle_o !== 1'b1 || dout_v_o[2] !== 1'b0) begin
      n_err++;
      $display("FAIL flush_idle: got idle=%b v=%b want 1/0", idle_o, dout_v_o[2]);
    end
    for (int i = 0; i < 2; i++) begin
      edge_();
      tick();
    end
    edge_();
    din_v_i[0] = 1'b1;
    din_i[0]   = 32'h77;
    exp_out[2].push_back(32'h77);
    tick();
    edge_();
    din_v_i[0] = 1'b0;
    tick();
    edge_();
    tick();
    sb_end("flush");
  endtask

  task automatic test_back_to_back();
    int w;
    set_conf(mk_conf({3'd0, 3'd1, 3'd0, 3'd0}, '0, 4'hF));
    w = 0;
    for (int i = 0; i < 60 && w < 8; i++) begin
      edge_();
      din_v_i[0]  = 1'b1;
      din_i[0]    = 32'hB00 + w;
      dout_r_i[2] = 1'($urandom_range(0, 1));
      tick();
      if (din_r_o[0]) begin
        exp_out[2].push_back(32'hB00 + w);
        w++;
      end
    end
    n_cmp++;
    if (w != 8) begin
      n_err++;
      $display("FAIL b2b_accept: got %0d want 8", w);
    end
    edge_();
    din_v_i[0]  = 1'b0;
    dout_r_i[2] = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      edge_();
      tick();
    end
    sb_end("b2b");
  endtask

  initial begin
    test_reset();
    test_route();
    test_fork();
    test_bypass();
    test_cell();
    test_flush();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
